// File: rtl/cmp_pkg.sv
// cmp_pkg: shared compare op codes, FSM states, relation encoding and op legality check.
package cmp_pkg;
    localparam logic [3:0] OP_EQ = 4'b0111;
    localparam logic [3:0] OP_NE = 4'b1001;
    localparam logic [3:0] OP_GT = 4'b1010;
    localparam logic [3:0] OP_LT = 4'b1011;
    localparam logic [3:0] OP_GE = 4'b1110;
    localparam logic [3:0] OP_LE = 4'b1111;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;
    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {OP_EQ, OP_NE, OP_GT, OP_LT, OP_GE, OP_LE};
    endfunction
endpackage

// File: rtl/cmp_unit.sv
// cmp_unit: 8-bit unsigned ALU comparator returning 8'h01 when the selected relation holds.
module cmp_unit
    import cmp_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op_sel,
    output logic [7:0] result
);
    always_comb begin
        result = {7'b0, op_sel == OP_EQ ? a == b :
                        op_sel == OP_NE ? a != b :
                        op_sel == OP_GT ? a > b  :
                        op_sel == OP_LT ? a < b  :
                        op_sel == OP_GE ? a >= b :
                        op_sel == OP_LE ? a <= b : 1'b0};
    end
endmodule

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: multi-byte unsigned compare sequencer scanning byte lanes MSB first
// with early exit on the first differing lane.
module cmp_seq_ctrl
    import cmp_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic [3:0]          op_sel,
    output logic                busy,
    output logic                done,
    output logic [7:0]          result,
    output logic                err
);
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;

    state_t              state, state_n;
    rel_t                rel_n;
    logic [8*NBYTES-1:0] a_q, b_q;
    logic [3:0]          op_q, op_eff;
    logic [IW-1:0]       idx;
    logic [7:0]          lane_a, lane_b, eq_r, lt_r;
    logic                eq, lt, fin;

    function automatic logic rel_holds(input rel_t rel, input logic [3:0] op);
        return op == OP_EQ ? rel == REL_EQ :
               op == OP_NE ? rel != REL_EQ :
               op == OP_GT ? rel == REL_GT :
               op == OP_LT ? rel == REL_LT :
               op == OP_GE ? rel != REL_LT :
               op == OP_LE ? rel != REL_GT : 1'b0;
    endfunction

    assign lane_a = a_q[{idx, 3'b000} +: 8];
    assign lane_b = b_q[{idx, 3'b000} +: 8];

    cmp_unit u_eq (.a(lane_a), .b(lane_b), .op_sel(OP_EQ), .result(eq_r));
    cmp_unit u_lt (.a(lane_a), .b(lane_b), .op_sel(OP_LT), .result(lt_r));

    // Upper bits of the comparator result are always zero, so OR-reduce equals bit 0.
    assign eq     = |eq_r;
    assign lt     = |lt_r;
    assign busy   = state != IDLE;
    // An illegal op finishes straight from IDLE, before the op has been latched.
    assign op_eff = state == IDLE ? op_sel : op_q;

    always_comb begin
        state_n = state;
        rel_n   = REL_EQ;
        fin     = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = is_legal_op(op_sel) ? SCAN : DONE;
                fin     = !is_legal_op(op_sel);
            end
            SCAN: if (!eq || idx == '0) begin
                state_n = DONE;
                fin     = 1'b1;
                rel_n   = eq ? REL_EQ : lt ? REL_LT : REL_GT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= 8'h00;
            err    <= 1'b0;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
        end else begin
            state <= state_n;
            done  <= state == DONE;
            if (state == IDLE && start) begin
                a_q  <= op_a;
                b_q  <= op_b;
                op_q <= op_sel;
                idx  <= IW'(NBYTES - 1);
            end else if (state == SCAN && eq && idx != '0) begin
                idx <= idx - 1'b1;
            end
            if (fin) begin
                result <= {7'b0, rel_holds(rel_n, op_eff)};
                err    <= !is_legal_op(op_eff);
            end
        end
    end
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: table-driven bench for cmp_seq_ctrl (NBYTES=4) plus hand-written
// corner sequences for ignored start and mid-scan reset.
module tb_cmp_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [3:0]  op_sel = '0;
    logic        busy, done, err;
    logic [7:0]  result;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [7:0]  res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t v[11];

    cmp_seq_ctrl #(.NBYTES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .op_sel(op_sel), .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request and measure edges from accept (E0) until done is seen.
    task automatic run(input vec_t t, input string name);
        int lat;
        lat = 0;
        @(negedge clk);
        op_a = t.a; op_b = t.b; op_sel = t.op; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, lat, t.lat);
        check({name, " result"}, int'(result), int'(t.res));
        check({name, " err"}, int'(err), int'(t.err));
        check({name, " busy_at_done"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        v[0]  = '{32'h12345678, 32'h12345678, 4'b0111, 8'h01, 1'b0, 5};
        v[1]  = '{32'h80000000, 32'h7FFFFFFF, 4'b1010, 8'h01, 1'b0, 2};
        v[2]  = '{32'h80000000, 32'h7FFFFFFF, 4'b1011, 8'h00, 1'b0, 2};
        v[3]  = '{32'h00000001, 32'h00000002, 4'b1111, 8'h01, 1'b0, 5};
        v[4]  = '{32'h00000001, 32'h00000002, 4'b1110, 8'h00, 1'b0, 5};
        v[5]  = '{32'hDEADBEEF, 32'h01234567, 4'b0101, 8'h00, 1'b1, 1};
        v[6]  = '{32'h00FF0000, 32'h00FE0000, 4'b1001, 8'h01, 1'b0, 3};
        v[7]  = '{32'hCAFEF00D, 32'hCAFEF00D, 4'b1110, 8'h01, 1'b0, 5};
        v[8]  = '{32'h00000010, 32'h00000020, 4'b1011, 8'h01, 1'b0, 5};
        v[9]  = '{32'h00000000, 32'h00000000, 4'b0000, 8'h00, 1'b1, 1};
        v[10] = '{32'h00001000, 32'h00002000, 4'b1010, 8'h00, 1'b0, 4};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset result", int'(result), 0);
        check("reset err", int'(err), 0);

        for (int i = 0; i < 11; i++) run(v[i], $sformatf("vec%0d", i));
        @(posedge clk);
        #1 check("done single cycle", int'(done), 0);

        // start during SCAN must be ignored and not disturb latched operands
        @(negedge clk);
        op_a = 32'd5; op_b = 32'd5; op_sel = 4'b0111; start = 1'b1;
        @(posedge clk);
        #1 op_a = 32'd1; op_b = 32'd9; op_sel = 4'b1011;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 if (done) n++;
        end
        check("busy start ignored pulses", n, 1);
        check("busy start ignored result", int'(result), 1);
        check("busy start ignored err", int'(err), 0);

        // reset mid-SCAN drops the request
        @(negedge clk);
        op_a = 32'h00000001; op_b = 32'h00000002; op_sel = 4'b1011; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 check("midscan busy before rst", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midscan rst busy", int'(busy), 0);
        check("midscan rst result", int'(result), 0);
        check("midscan rst err", int'(err), 0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 if (done) n++;
        end
        check("midscan rst no done", n, 0);
        run(v[1], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
